// File: rtl/fp_regfile_sb.sv
// -----------------------------------------------------------------------------
// fp_regfile_sb
//   Register file with three combinational read ports and two write ports,
//   plus a pending-write scoreboard for multi-cycle producers.
//     - Write port A carries single-cycle ALU writeback.
//     - Write port B carries multi-cycle FP-unit writeback. If both ports write
//       the same address in one cycle, port B wins.
//     - The scoreboard marks the destination of each issued multi-cycle op as
//       busy. The first write that lands on that register clears the mark.
//
// Parameters
//   WIDTH  data bits per register
//   DEPTH  number of registers (power of two, >= 2)
//   AW     address width, derived from DEPTH
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   ra1..ra3            read addresses
//   rd1..rd3            read data (combinational, same-cycle write bypass)
//   busy1..busy3        read register has a write pending that has not landed
//   we_a/wa_a/wd_a      write port A (enable, address, data)
//   we_b/wa_b/wd_b      write port B (enable, address, data)
//   iss_v/iss_rd        issue of a multi-cycle op and its destination
//   iss_waw             issue targets a register that is still pending
//   wr_coll             registered flag: both ports wrote one address last cycle
//
// Build option
//   ZERO_REG_EN  when defined, register 0 reads as zero, ignores writes, never
//                becomes pending and takes no part in bypass or collision.
//                When undefined, register 0 is an ordinary register.
// -----------------------------------------------------------------------------
module fp_regfile_sb #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    ra3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic             busy1,
  output logic             busy2,
  output logic             busy3,
  input  logic             we_a,
  input  logic [AW-1:0]    wa_a,
  input  logic [WIDTH-1:0] wd_a,
  input  logic             we_b,
  input  logic [AW-1:0]    wa_b,
  input  logic [WIDTH-1:0] wd_b,
  input  logic             iss_v,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_waw,
  output logic             wr_coll
);

  logic [WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0] pending;

  // Effective enables: with a hardwired zero register, any write or issue
  // that targets address 0 is dropped here, so the array, bypass, collision
  // and scoreboard logic below never see it.
  logic wen_a;
  logic wen_b;
  logic iss_en;

  always_comb begin
`ifdef ZERO_REG_EN
    wen_a  = we_a  && (wa_a   != '0);
    wen_b  = we_b  && (wa_b   != '0);
    iss_en = iss_v && (iss_rd != '0);
`else
    wen_a  = we_a;
    wen_b  = we_b;
    iss_en = iss_v;
`endif
  end

  // Per-register decode of the scoreboard events for this cycle.
  logic [DEPTH-1:0] set_v;
  logic [DEPTH-1:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_en) set_v[iss_rd] = 1'b1;
    if (wen_a)  clr_v[wa_a]   = 1'b1;
    if (wen_b)  clr_v[wa_b]   = 1'b1;
  end

  // Read ports, gathered into arrays so that all three share one body.
  logic [AW-1:0]    ra_v   [3];
  logic [WIDTH-1:0] rd_v   [3];
  logic             busy_v [3];

  assign ra_v[0] = ra1;
  assign ra_v[1] = ra2;
  assign ra_v[2] = ra3;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    always_comb begin
      rd_v[p]   = '0;
      busy_v[p] = 1'b0;
      if (!reset) begin
        // Port B is checked first so that a same-address collision returns
        // the value the array will hold after the edge.
        if (wen_b && (ra_v[p] == wa_b))
          rd_v[p] = wd_b;
        else if (wen_a && (ra_v[p] == wa_a))
          rd_v[p] = wd_a;
        else
          rd_v[p] = rf[ra_v[p]];
        // A write landing this cycle already bypasses its data, so the
        // register is reported free in the same cycle.
        busy_v[p] = pending[ra_v[p]] && !clr_v[ra_v[p]];
      end
`ifdef ZERO_REG_EN
      if (ra_v[p] == '0) begin
        rd_v[p]   = '0;
        busy_v[p] = 1'b0;
      end
`endif
    end
  end

  assign rd1   = rd_v[0];
  assign rd2   = rd_v[1];
  assign rd3   = rd_v[2];
  assign busy1 = busy_v[0];
  assign busy2 = busy_v[1];
  assign busy3 = busy_v[2];

  // Stall hint only. The issue still sets the bit, and a same-cycle landing
  // write to the same register means the old producer has just finished.
  assign iss_waw = !reset && iss_v && pending[iss_rd] && !clr_v[iss_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++)
        rf[r[AW-1:0]] <= '0;
      pending <= '0;
      wr_coll <= 1'b0;
    end else begin
      if (wen_a) rf[wa_a] <= wd_a;
      // The later assignment takes effect, so port B wins a collision.
      if (wen_b) rf[wa_b] <= wd_b;
      // An issue has priority over a same-cycle clear because it names a
      // new producer for that register.
      pending <= set_v | (pending & ~clr_v);
      wr_coll <= wen_a && wen_b && (wa_a == wa_b);
    end
  end

endmodule

// File: tb/tb_fp_regfile_sb.sv
module tb_fp_regfile_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  ra1, ra2, ra3;
  logic [31:0] rd1, rd2, rd3;
  logic        busy1, busy2, busy3;
  logic        we_a, we_b, iss_v;
  logic [4:0]  wa_a, wa_b, iss_rd;
  logic [31:0] wd_a, wd_b;
  logic        iss_waw, wr_coll;

  int checks;
  int failures;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  fp_regfile_sb #(.WIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .busy1(busy1), .busy2(busy2), .busy3(busy3),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .iss_v(iss_v), .iss_rd(iss_rd),
    .iss_waw(iss_waw), .wr_coll(wr_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    we_a = 0; we_b = 0; iss_v = 0;
    wa_a = 0; wa_b = 0; iss_rd = 0;
    wd_a = 0; wd_b = 0;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time
  // unit later, well away from the rising edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    next_cycle();
    reset = 1; we_b = 1; wa_b = 3; wd_b = 32'hDEAD; iss_v = 1; iss_rd = 3;
    ra1 = 3; ra2 = 3; ra3 = 0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL rst_rd1 got=%h exp=%h", rd1, e); end
    e = exp_q.pop_front(); checks++; if (rd2 !== e) begin failures++; $display("FAIL rst_rd2 got=%h exp=%h", rd2, e); end
    e = exp_q.pop_front(); checks++; if (rd3 !== e) begin failures++; $display("FAIL rst_rd3 got=%h exp=%h", rd3, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL rst_busy1 got=%b exp=%h", busy1, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, iss_waw} !== e) begin failures++; $display("FAIL rst_iss_waw got=%b exp=%h", iss_waw, e); end
    next_cycle();
    idle();
    reset = 0;
    exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, wr_coll} !== e) begin failures++; $display("FAIL rst_wr_coll got=%b exp=%h", wr_coll, e); end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i); ra3 = 5'(i);
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      #1;
      e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL rst_read_rd1 a=%0d got=%h exp=%h", i, rd1, e); end
      e = exp_q.pop_front(); checks++; if (rd2 !== e) begin failures++; $display("FAIL rst_read_rd2 a=%0d got=%h exp=%h", 31 - i, rd2, e); end
      e = exp_q.pop_front(); checks++; if (rd3 !== e) begin failures++; $display("FAIL rst_read_rd3 a=%0d got=%h exp=%h", i, rd3, e); end
      e = exp_q.pop_front(); checks++; if ({29'b0, busy1, busy2, busy3} !== e) begin failures++; $display("FAIL rst_read_busy a=%0d got=%b%b%b exp=%h", i, busy1, busy2, busy3, e); end
    end
  endtask

  task automatic test_bypass();
    next_cycle();
    idle();
    we_a = 1; wa_a = 5; wd_a = 32'h3F800000; ra1 = 5;
    exp_q.push_back(32'h3F800000);
    #1;
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL bypass_a_rd1 got=%h exp=%h", rd1, e); end
    next_cycle();
    idle();
    exp_q.push_back(32'h3F800000);
    #1;
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL array_rd1 got=%h exp=%h", rd1, e); end
    // Two ports writing distinct addresses: each read sees its own writer.
    next_cycle();
    we_a = 1; wa_a = 10; wd_a = 32'hAAAA_0001; we_b = 1; wa_b = 11; wd_b = 32'hBBBB_0002;
    ra1 = 10; ra2 = 11; ra3 = 5;
    exp_q.push_back(32'hAAAA_0001); exp_q.push_back(32'hBBBB_0002); exp_q.push_back(32'h3F800000);
    #1;
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL dual_rd1 got=%h exp=%h", rd1, e); end
    e = exp_q.pop_front(); checks++; if (rd2 !== e) begin failures++; $display("FAIL dual_rd2 got=%h exp=%h", rd2, e); end
    e = exp_q.pop_front(); checks++; if (rd3 !== e) begin failures++; $display("FAIL dual_rd3 got=%h exp=%h", rd3, e); end
    next_cycle();
    idle();
    exp_q.push_back(32'hAAAA_0001); exp_q.push_back(32'hBBBB_0002); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL dual_arr_rd1 got=%h exp=%h", rd1, e); end
    e = exp_q.pop_front(); checks++; if (rd2 !== e) begin failures++; $display("FAIL dual_arr_rd2 got=%h exp=%h", rd2, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, wr_coll} !== e) begin failures++; $display("FAIL dual_wr_coll got=%b exp=%h", wr_coll, e); end
  endtask

  task automatic test_collision();
    next_cycle();
    idle();
    we_a = 1; we_b = 1; wa_a = 7; wa_b = 7; wd_a = 1; wd_b = 2; ra2 = 7;
    exp_q.push_back(2); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if (rd2 !== e) begin failures++; $display("FAIL coll_bypass_rd2 got=%h exp=%h", rd2, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, wr_coll} !== e) begin failures++; $display("FAIL coll_early got=%b exp=%h", wr_coll, e); end
    next_cycle();
    idle();
    exp_q.push_back(2); exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); checks++; if (rd2 !== e) begin failures++; $display("FAIL coll_array_rd2 got=%h exp=%h", rd2, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, wr_coll} !== e) begin failures++; $display("FAIL coll_flag got=%b exp=%h", wr_coll, e); end
    next_cycle();
    exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, wr_coll} !== e) begin failures++; $display("FAIL coll_one_cycle got=%b exp=%h", wr_coll, e); end
  endtask

  task automatic test_scoreboard();
    next_cycle();
    idle();
    ra1 = 9; ra2 = 12; iss_v = 1; iss_rd = 9;
    exp_q.push_back(0); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL sb_issue_cycle_busy got=%b exp=%h", busy1, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, iss_waw} !== e) begin failures++; $display("FAIL sb_first_waw got=%b exp=%h", iss_waw, e); end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      idle();
      exp_q.push_back(1); exp_q.push_back(0);
      #1;
      e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL sb_pending_busy1 c=%0d got=%b exp=%h", c, busy1, e); end
      e = exp_q.pop_front(); checks++; if ({31'b0, busy2} !== e) begin failures++; $display("FAIL sb_other_busy2 c=%0d got=%b exp=%h", c, busy2, e); end
    end
    next_cycle();
    we_b = 1; wa_b = 9; wd_b = 42;
    exp_q.push_back(0); exp_q.push_back(42);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL sb_land_busy1 got=%b exp=%h", busy1, e); end
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL sb_land_rd1 got=%h exp=%h", rd1, e); end
    next_cycle();
    idle();
    iss_v = 1; iss_rd = 9;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(42);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL sb_cleared_busy1 got=%b exp=%h", busy1, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, iss_waw} !== e) begin failures++; $display("FAIL sb_reissue_waw got=%b exp=%h", iss_waw, e); end
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL sb_array_rd1 got=%h exp=%h", rd1, e); end
    next_cycle();
    exp_q.push_back(1); exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, iss_waw} !== e) begin failures++; $display("FAIL sb_waw got=%b exp=%h", iss_waw, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL sb_waw_busy1 got=%b exp=%h", busy1, e); end
    // Issue and landing write to the same register in one cycle.
    next_cycle();
    we_b = 1; wa_b = 9; wd_b = 7;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(7);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, iss_waw} !== e) begin failures++; $display("FAIL sb_land_waw got=%b exp=%h", iss_waw, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL sb_land2_busy1 got=%b exp=%h", busy1, e); end
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL sb_land2_rd1 got=%h exp=%h", rd1, e); end
    next_cycle();
    idle();
    exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL sb_set_wins got=%b exp=%h", busy1, e); end
    // An ALU write also clears a pending register.
    next_cycle();
    we_a = 1; wa_a = 9; wd_a = 32'h55;
    exp_q.push_back(0); exp_q.push_back(32'h55);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL sb_a_land_busy1 got=%b exp=%h", busy1, e); end
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL sb_a_land_rd1 got=%h exp=%h", rd1, e); end
    next_cycle();
    idle();
    exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL sb_a_cleared got=%b exp=%h", busy1, e); end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    idle();
    iss_v = 1; iss_rd = 4;
    next_cycle();
    idle();
    ra1 = 4;
    exp_q.push_back(1);
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL rmid_pre_busy1 got=%b exp=%h", busy1, e); end
    next_cycle();
    reset = 1; we_b = 1; wa_b = 4; wd_b = 55; we_a = 1; wa_a = 4; wd_a = 66;
    iss_v = 1; iss_rd = 4; ra1 = 4; ra2 = 5; ra3 = 11;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL rmid_rd1 got=%h exp=%h", rd1, e); end
    e = exp_q.pop_front(); checks++; if (rd2 !== e) begin failures++; $display("FAIL rmid_rd2 got=%h exp=%h", rd2, e); end
    e = exp_q.pop_front(); checks++; if (rd3 !== e) begin failures++; $display("FAIL rmid_rd3 got=%h exp=%h", rd3, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL rmid_busy1 got=%b exp=%h", busy1, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, iss_waw} !== e) begin failures++; $display("FAIL rmid_waw got=%b exp=%h", iss_waw, e); end
    next_cycle();
    idle();
    reset = 0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL rmid_after_rd1 got=%h exp=%h", rd1, e); end
    e = exp_q.pop_front(); checks++; if (rd2 !== e) begin failures++; $display("FAIL rmid_after_rd2 got=%h exp=%h", rd2, e); end
    e = exp_q.pop_front(); checks++; if (rd3 !== e) begin failures++; $display("FAIL rmid_after_rd3 got=%h exp=%h", rd3, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL rmid_after_busy1 got=%b exp=%h", busy1, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, wr_coll} !== e) begin failures++; $display("FAIL rmid_after_coll got=%b exp=%h", wr_coll, e); end
  endtask

  task automatic test_zero_reg();
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic        exp_coll;
`ifdef ZERO_REG_EN
    exp_rd = 32'h0; exp_busy = 1'b0; exp_coll = 1'b0;
`else
    exp_rd = 32'hFFFF_FFFF; exp_busy = 1'b1; exp_coll = 1'b1;
`endif
    next_cycle();
    idle();
    we_a = 1; wa_a = 0; wd_a = 32'hFFFF_FFFF; iss_v = 1; iss_rd = 0; ra1 = 0;
    exp_q.push_back(exp_rd); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL zr_bypass_rd1 got=%h exp=%h", rd1, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL zr_issue_busy1 got=%b exp=%h", busy1, e); end
    next_cycle();
    idle();
    exp_q.push_back(exp_rd); exp_q.push_back({31'b0, exp_busy});
    #1;
    e = exp_q.pop_front(); checks++; if (rd1 !== e) begin failures++; $display("FAIL zr_array_rd1 got=%h exp=%h", rd1, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, busy1} !== e) begin failures++; $display("FAIL zr_busy1 got=%b exp=%h", busy1, e); end
    next_cycle();
    we_a = 1; we_b = 1; wa_a = 0; wa_b = 0; wd_a = 3; wd_b = 4;
    next_cycle();
    idle();
    exp_q.push_back({31'b0, exp_coll});
    #1;
    e = exp_q.pop_front(); checks++; if ({31'b0, wr_coll} !== e) begin failures++; $display("FAIL zr_coll got=%b exp=%h", wr_coll, e); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1;
    ra1 = 0; ra2 = 0; ra3 = 0;
    idle();
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_reset_mid();
    test_zero_reg();
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
